// File: rtl/image_in_roi_pkg.sv
// Shared constants and state type for the ROI fetch controller.
// Optional feature macro: ROI_CLAMP_EN (clamp bounds to the frame).
package image_in_roi_pkg;

    localparam int unsigned FRAME_W = 1242;
    localparam int unsigned FRAME_H = 375;

    localparam int unsigned HOR_W = 11;
    localparam int unsigned VER_W = 9;
    localparam int unsigned PIX_W = 24;
    localparam int unsigned CNT_W = 19;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        REQUEST,
        STREAM
    } roi_state_e;

endpackage

// File: rtl/image_in_roi_normalize.sv
// roi_normalize: orders each axis min/max, optionally clamps to the frame,
// and derives the inclusive window size.
// Optional feature macro: ROI_CLAMP_EN (clamp bounds to the frame).
module roi_normalize
    import image_in_roi_pkg::*;
`ifdef ROI_CLAMP_EN
#(
    parameter logic [HOR_W-1:0] HOR_LIM = HOR_W'(FRAME_W - 1),
    parameter logic [VER_W-1:0] VER_LIM = VER_W'(FRAME_H - 1)
)
`endif
(
    input  logic [HOR_W-1:0] hor_min_i,
    input  logic [HOR_W-1:0] hor_max_i,
    input  logic [VER_W-1:0] ver_min_i,
    input  logic [VER_W-1:0] ver_max_i,
    output logic [HOR_W-1:0] hor_min_o,
    output logic [HOR_W-1:0] hor_max_o,
    output logic [VER_W-1:0] ver_min_o,
    output logic [VER_W-1:0] ver_max_o,
    output logic [HOR_W-1:0] width_o,
    output logic [VER_W-1:0] height_o
);

    // Swap reversed bounds, clamp if enabled, then compute sizes
    always_comb begin
        hor_min_o = (hor_min_i > hor_max_i) ? hor_max_i : hor_min_i;
        hor_max_o = (hor_min_i > hor_max_i) ? hor_min_i : hor_max_i;
        ver_min_o = (ver_min_i > ver_max_i) ? ver_max_i : ver_min_i;
        ver_max_o = (ver_min_i > ver_max_i) ? ver_min_i : ver_max_i;
`ifdef ROI_CLAMP_EN
        if (hor_min_o > HOR_LIM) hor_min_o = HOR_LIM;
        if (hor_max_o > HOR_LIM) hor_max_o = HOR_LIM;
        if (ver_min_o > VER_LIM) ver_min_o = VER_LIM;
        if (ver_max_o > VER_LIM) ver_max_o = VER_LIM;
`endif
        width_o  = hor_max_o - hor_min_o + HOR_W'(1);
        height_o = ver_max_o - ver_min_o + VER_W'(1);
    end

endmodule

// File: rtl/image_in_roi.sv
// image_in_roi: captures a bounding box, offers the normalised window
// downstream, pulses a frame request and forwards the returned pixels
// until width*height data-enabled pixels have passed or the source
// signals an early frame end.
// Optional feature macro: ROI_CLAMP_EN (clamp bounds to the frame).
module image_in_roi
    import image_in_roi_pkg::*;
#(
    parameter int unsigned FRAME_W = image_in_roi_pkg::FRAME_W,
    parameter int unsigned FRAME_H = image_in_roi_pkg::FRAME_H
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [HOR_W-1:0] HorMinIn,
    input  logic [HOR_W-1:0] HorMaxIn,
    input  logic [VER_W-1:0] VerMinIn,
    input  logic [VER_W-1:0] VerMaxIn,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             ARMImgRequest,
    output logic [HOR_W-1:0] HorMinOut,
    output logic [HOR_W-1:0] HorMaxOut,
    output logic [VER_W-1:0] VerMinOut,
    output logic [VER_W-1:0] VerMaxOut,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             de_in,
    input  logic             vsync_in,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [PIX_W-1:0] pixel_out,
    output logic             de_out,
    output logic             vsync_out,
    output logic [HOR_W-1:0] OutWidth,
    output logic [VER_W-1:0] OutHeight
);

    // Whole-frame pixel count must fit the de counter
    if (FRAME_W * FRAME_H >= (32'd1 << CNT_W)) begin : g_cnt_range
        $error("frame area exceeds pixel counter range");
    end

    roi_state_e state_q, state_d;

    logic [HOR_W-1:0] hmin_q, hmax_q, width_q;
    logic [VER_W-1:0] vmin_q, vmax_q, height_q;
    logic [HOR_W-1:0] n_hmin, n_hmax, n_width;
    logic [VER_W-1:0] n_vmin, n_vmax, n_height;
    logic [CNT_W-1:0] prod_q, cnt_q;
    logic [PIX_W-1:0] pix_q;
    logic             de_q, vs_q, vs_prev_q;
    logic             capture, fwd, done, premature;

    roi_normalize
`ifdef ROI_CLAMP_EN
    #(
        .HOR_LIM(HOR_W'(FRAME_W - 1)),
        .VER_LIM(VER_W'(FRAME_H - 1))
    )
`endif
    u_norm (
        .hor_min_i(HorMinIn),
        .hor_max_i(HorMaxIn),
        .ver_min_i(VerMinIn),
        .ver_max_i(VerMaxIn),
        .hor_min_o(n_hmin),
        .hor_max_o(n_hmax),
        .ver_min_o(n_vmin),
        .ver_max_o(n_vmax),
        .width_o  (n_width),
        .height_o (n_height)
    );

    // Window complete, or a fresh vsync once pixels have started arriving
    assign done      = (cnt_q == prod_q);
    assign premature = vsync_in & ~vs_prev_q & (cnt_q != '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        fwd           = 1'b0;
        ready_out     = 1'b0;
        valid_out     = 1'b1;
        ARMImgRequest = 1'b0;
        case (state_q)
            IDLE: begin
                ready_out = 1'b1;
                valid_out = 1'b0;
                if (valid_in) begin
                    capture = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (ready_in) state_d = REQUEST;
            end
            REQUEST: begin
                ARMImgRequest = 1'b1;
                state_d       = STREAM;
            end
            STREAM: begin
                if (done || premature) state_d = IDLE;
                else                   fwd     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Window capture, size product, de counter and pixel pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            hmin_q    <= '0;
            hmax_q    <= '0;
            vmin_q    <= '0;
            vmax_q    <= '0;
            width_q   <= '0;
            height_q  <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            pix_q     <= '0;
            de_q      <= 1'b0;
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            if (capture) begin
                hmin_q   <= n_hmin;
                hmax_q   <= n_hmax;
                vmin_q   <= n_vmin;
                vmax_q   <= n_vmax;
                width_q  <= n_width;
                height_q <= n_height;
                cnt_q    <= '0;
            end
            if (state_q == OFFER) prod_q <= CNT_W'(width_q) * CNT_W'(height_q);
            if (fwd && de_in) cnt_q <= cnt_q + CNT_W'(1);
            pix_q     <= fwd ? pixel_in : '0;
            de_q      <= fwd & de_in;
            vs_q      <= fwd & vsync_in;
            vs_prev_q <= (state_q == STREAM) & vsync_in;
        end
    end

    assign HorMinOut = hmin_q;
    assign HorMaxOut = hmax_q;
    assign VerMinOut = vmin_q;
    assign VerMaxOut = vmax_q;
    assign OutWidth  = width_q;
    assign OutHeight = height_q;
    assign pixel_out = pix_q;
    assign de_out    = de_q;
    assign vsync_out = vs_q;

endmodule

// File: tb/tb_image_in_roi.sv
// Self-checking bench for image_in_roi: directed cases plus randomised
// boxes and streams, checked against a cycle-scheduled reference model.
// Honours ROI_CLAMP_EN the same way as the design.
module tb_image_in_roi;

    localparam int unsigned HLIM = 1242 - 1;
    localparam int unsigned VLIM = 375 - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] HorMinIn, HorMaxIn;
    logic [8:0]  VerMinIn, VerMaxIn;
    logic        valid_in, ready_out, ARMImgRequest;
    logic [10:0] HorMinOut, HorMaxOut;
    logic [8:0]  VerMinOut, VerMaxOut;
    logic [23:0] pixel_in, pixel_out;
    logic        de_in, vsync_in, ready_in, valid_out, de_out, vsync_out;
    logic [10:0] OutWidth;
    logic [8:0]  OutHeight;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    image_in_roi dut (
        .clk          (clk),
        .reset        (reset),
        .HorMinIn     (HorMinIn),
        .HorMaxIn     (HorMaxIn),
        .VerMinIn     (VerMinIn),
        .VerMaxIn     (VerMaxIn),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .ARMImgRequest(ARMImgRequest),
        .HorMinOut    (HorMinOut),
        .HorMaxOut    (HorMaxOut),
        .VerMinOut    (VerMinOut),
        .VerMaxOut    (VerMaxOut),
        .pixel_in     (pixel_in),
        .de_in        (de_in),
        .vsync_in     (vsync_in),
        .ready_in     (ready_in),
        .valid_out    (valid_out),
        .pixel_out    (pixel_out),
        .de_out       (de_out),
        .vsync_out    (vsync_out),
        .OutWidth     (OutWidth),
        .OutHeight    (OutHeight)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Ordered, optionally clamped bounds of one axis
    function automatic void norm_axis(input int unsigned a, input int unsigned b,
                                      input int unsigned lim,
                                      output int unsigned lo, output int unsigned hi);
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
`ifdef ROI_CLAMP_EN
        if (lo > lim) lo = lim;
        if (hi > lim) hi = lim;
`else
        lim = lim;
`endif
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, ready_out, 1);
        check({tag, "_valid"}, valid_out, 0);
        check({tag, "_req"},   ARMImgRequest, 0);
        check({tag, "_hmin"},  HorMinOut, 0);
        check({tag, "_hmax"},  HorMaxOut, 0);
        check({tag, "_vmin"},  VerMinOut, 0);
        check({tag, "_vmax"},  VerMaxOut, 0);
        check({tag, "_w"},     OutWidth, 0);
        check({tag, "_h"},     OutHeight, 0);
        check({tag, "_pix"},   pixel_out, 0);
        check({tag, "_de"},    de_out, 0);
        check({tag, "_vs"},    vsync_out, 0);
    endtask

    // Idle cycles with source noise that must not leak through
    task automatic idle_gap(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            valid_in = 1'b0;
            de_in    = 1'(($urandom) & 1);
            vsync_in = 1'(($urandom) & 1);
            pixel_in = 24'($urandom);
            tick();
            check("idle_ready", ready_out, 1);
            check("idle_valid", valid_out, 0);
            check("idle_de", de_out, 0);
            check("idle_pix", pixel_out, 0);
        end
        de_in    = 1'b0;
        vsync_in = 1'b0;
    endtask

    // One full transaction; pre_after/abort_after >= 0 inject an early
    // vsync or a reset once that many pixels have been counted
    task automatic run_roi(input int unsigned hmin, input int unsigned hmax,
                           input int unsigned vmin, input int unsigned vmax,
                           input int unsigned wait_cyc, input int pre_after,
                           input int abort_after);
        int unsigned hlo, hhi, vlo, vhi, w, h, n, counted;
        bit          prev_vs, fwd, prem, ended;
        bit          de, vs;
        logic [23:0] px;

        norm_axis(hmin, hmax, HLIM, hlo, hhi);
        norm_axis(vmin, vmax, VLIM, vlo, vhi);
        w = hhi - hlo + 1;
        h = vhi - vlo + 1;
        n = w * h;

        check("cap_ready", ready_out, 1);
        HorMinIn = 11'(hmin);
        HorMaxIn = 11'(hmax);
        VerMinIn = 9'(vmin);
        VerMaxIn = 9'(vmax);
        valid_in = 1'b1;
        ready_in = 1'b0;
        tick();
        HorMinIn = 11'($urandom);
        HorMaxIn = 11'($urandom);
        VerMinIn = 9'($urandom);
        VerMaxIn = 9'($urandom);
        valid_in = 1'(($urandom) & 1);
        check("offer_valid", valid_out, 1);
        check("offer_ready", ready_out, 0);
        check("offer_req", ARMImgRequest, 0);
        check("win_hmin", HorMinOut, hlo);
        check("win_hmax", HorMaxOut, hhi);
        check("win_vmin", VerMinOut, vlo);
        check("win_vmax", VerMaxOut, vhi);
        check("win_width", OutWidth, w);
        check("win_height", OutHeight, h);

        for (int unsigned i = 0; i < wait_cyc; i++) begin
            ready_in = 1'b0;
            tick();
            check("wait_noreq", ARMImgRequest, 0);
            check("wait_valid", valid_out, 1);
        end
        ready_in = 1'b1;
        tick();
        check("req_pulse", ARMImgRequest, 1);
        check("req_valid", valid_out, 1);

        ready_in = 1'(($urandom) & 1);
        de_in    = 1'b1;
        pixel_in = 24'($urandom);
        vsync_in = 1'b0;
        tick();
        check("req_once", ARMImgRequest, 0);
        check("req_nofwd", de_out, 0);

        counted = 0;
        prev_vs = 1'b0;
        ended   = 1'b0;
        for (int unsigned cyc = 0; cyc < 4 * n + 64; cyc++) begin
            de = ($urandom_range(0, 3) != 0);
            px = 24'($urandom);
            vs = 1'b0;
            if (counted == 0 && $urandom_range(0, 7) == 0) vs = 1'b1;
            if (pre_after >= 0 && counted == int'(pre_after)) begin
                vs = 1'b1;
                de = 1'b1;
            end
            if (abort_after >= 0 && counted == int'(abort_after)) begin
                reset    = 1'b1;
                de_in    = 1'b1;
                pixel_in = px;
                tick();
                reset = 1'b0;
                check_reset_values("abort");
                for (int unsigned k = 0; k < 8; k++) begin
                    de_in    = 1'b1;
                    pixel_in = 24'($urandom);
                    vsync_in = 1'(($urandom) & 1);
                    tick();
                    check("post_abort_de", de_out, 0);
                    check("post_abort_pix", pixel_out, 0);
                    check("post_abort_ready", ready_out, 1);
                end
                de_in    = 1'b0;
                vsync_in = 1'b0;
                valid_in = 1'b0;
                return;
            end
            prem     = vs && !prev_vs && counted >= 1;
            fwd      = (counted < n) && !prem;
            de_in    = de;
            pixel_in = px;
            vsync_in = vs;
            prev_vs  = vs;
            tick();
            check("str_de", de_out, fwd && de);
            check("str_pix", pixel_out, fwd ? int'(px) : 0);
            check("str_vs", vsync_out, fwd && vs);
            check("str_ready", ready_out, !fwd);
            check("str_valid", valid_out, fwd);
            if (fwd && de) counted++;
            if (!fwd) begin
                ended = 1'b1;
                break;
            end
        end
        check("stream_end", ended, 1);
        de_in    = 1'b0;
        vsync_in = 1'b0;
        valid_in = 1'b0;
        check("hold_hmin", HorMinOut, hlo);
        check("hold_hmax", HorMaxOut, hhi);
        check("hold_vmin", VerMinOut, vlo);
        check("hold_vmax", VerMaxOut, vhi);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a, b, c, d, t;
        reset    = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        de_in    = 1'b0;
        vsync_in = 1'b0;
        pixel_in = '0;
        HorMinIn = '0;
        HorMaxIn = '0;
        VerMinIn = '0;
        VerMaxIn = '0;
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b0;
        idle_gap(2);

        run_roi(100, 163, 50, 81, 0, -1, -1);
        idle_gap(1);
        run_roi(200, 150, 40, 20, 2, -1, -1);
        idle_gap(1);
        run_roi(1200, 1500, 300, 450, 1, 2, -1);
        idle_gap(1);
        run_roi(300, 310, 100, 103, 10, -1, -1);
        idle_gap(1);
        run_roi(0, 511, 0, 63, 0, -1, 5);
        idle_gap(1);
        run_roi(10, 10, 5, 8, 0, 3, -1);
        idle_gap(1);
        run_roi(2047, 2047, 511, 511, 0, -1, -1);

        for (int unsigned i = 0; i < 20; i++) begin
            idle_gap($urandom_range(0, 3));
            a = $urandom_range(0, 2047);
            b = a + $urandom_range(0, 15);
            if (b > 2047) b = 2047;
            c = $urandom_range(0, 511);
            d = c + $urandom_range(0, 7);
            if (d > 511) d = 511;
            if ($urandom_range(0, 1) == 1) begin t = a; a = b; b = t; end
            if ($urandom_range(0, 1) == 1) begin t = c; c = d; d = t; end
            run_roi(a, b, c, d, $urandom_range(0, 3), -1, -1);
        end
        idle_gap(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/image_in_roi.md
# image_in_roi

Region-of-interest fetch controller between the 3-D-box-to-image projection stage and the image resizer. It accepts a pixel-space bounding box and normalises it to the 1242x375 camera frame. It requests exactly that window from the ARM-side frame source and forwards the returned pixel stream, with its width and height, to the downstream resizer.

## Interface
- FRAME_W, 1242, frame width in pixels.
- FRAME_H, 375, frame height in lines.
- clk  in  1  single system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- HorMinIn, HorMaxIn  in  11  requested column bounds, unsigned, inclusive.
- VerMinIn, VerMaxIn  in  9  requested row bounds, unsigned, inclusive.
- valid_in  in  1  bounds valid (upstream handshake).
- ready_out  out  1  block can accept bounds.
- ARMImgRequest  out  1  one-cycle request pulse to the frame source.
- HorMinOut, HorMaxOut, VerMinOut, VerMaxOut  out  11/11/9/9  normalised window, held stable from capture until return to IDLE.
- pixel_in  in  24  RGB from the frame source, {B,G,R}.
- de_in, vsync_in  in  1  source data-enable and frame sync.
- ready_in  in  1  downstream can accept a window.
- valid_out  out  1  window description and stream offered downstream.
- pixel_out  out  24  forwarded pixel.
- de_out, vsync_out  out  1  forwarded strobes.
- OutWidth  out  11  HorMaxOut-HorMinOut+1.
- OutHeight  out  9  VerMaxOut-VerMinOut+1.

## Operation
- States are IDLE, OFFER, REQUEST and STREAM.
- IDLE: ready_out=1. On valid_in&ready_out, capture and normalise the bounds, then go to OFFER.
- Normalise: swap min/max per axis if min>max. Clamp each column bound to FRAME_W-1 and each row bound to FRAME_H-1 (see Configuration).
- OFFER: valid_out=1, window outputs and OutWidth/OutHeight valid. On ready_in=1, go to REQUEST.
- REQUEST: ARMImgRequest=1 for exactly this cycle, then go to STREAM.
- STREAM: register pixel_in, de_in and vsync_in to pixel_out, de_out and vsync_out. Count cycles with de_in=1 in a 19-bit counter. When the count reaches OutWidth*OutHeight, return to IDLE.
- valid_out stays 1 through REQUEST and STREAM.
- Outside STREAM, de_out=0, vsync_out=0, pixel_out=0, and de_in/vsync_in are ignored.
- ready_out=0 in every state except IDLE. valid_in is ignored there.
- A vsync_in rising edge in STREAM after at least one pixel has been counted is a premature frame end: return to IDLE and forward no further pixels.
- Degenerate box (min==max on an axis) is legal and gives a size of 1 on that axis.

## Timing
- Reset values: state=IDLE, ready_out=1, valid_out=0, ARMImgRequest=0, all window, size, pixel and strobe outputs 0, counter 0.
- Reset mid-operation aborts immediately. The rest of any source stream is dropped.
- Capture to valid_out: 1 cycle. ready_in to ARMImgRequest: 1 cycle.
- Pixel path latency is exactly 1 cycle.
- On the cycle the final pixel is forwarded (de_out=1), the state returns to IDLE and ready_out=1 the next cycle.
- The count compare uses the registered product width*height, computed in OFFER.

## Configuration
- ROI_CLAMP_EN defined: bounds are clamped to FRAME_W-1/FRAME_H-1 during normalisation.
- ROI_CLAMP_EN undefined: no clamping; only the swap is applied and out-of-frame bounds pass through unchanged.

## Structure
- Package image_in_roi_pkg holds:
  - FRAME_W and FRAME_H defaults;
  - width constants HOR_W=11, VER_W=9, PIX_W=24, CNT_W=19;
  - the state enum {IDLE, OFFER, REQUEST, STREAM}.
- One sub-module, roi_normalize: combinational swap, clamp and size computation.

## Test plan
- Bounds H 100..163, V 50..81, ready_in=1 -> valid_out next cycle, OutWidth=64, OutHeight=32, one ARMImgRequest pulse; 2048 de pixels forwarded 1 cycle late, then ready_out=1.
- Swapped bounds H 200..150, V 40..20 -> HorMinOut=150, HorMaxOut=200, VerMinOut=20, VerMaxOut=40, OutWidth=51, OutHeight=21.
- With ROI_CLAMP_EN, H 1200..1500, V 300..450 -> HorMaxOut=1241, VerMaxOut=374, OutWidth=42, OutHeight=75.
- ready_in held 0 for 10 cycles in OFFER -> no ARMImgRequest and valid_out stays 1; request issued 1 cycle after ready_in rises.
- Reset asserted mid-STREAM after 5 pixels -> next cycle all outputs at reset values; later source pixels not forwarded.
- Premature vsync_in after 3 of 4 pixels (1x4 window) -> return to IDLE; the 4th source pixel is not forwarded.
